// File: rtl/vram_draw_ctrl_if.sv
// vram_draw_ctrl_if: command, sprite, scanout and VRAM port bundle for the draw controller
interface vram_draw_ctrl_if #(parameter int BITS = 14);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_op;
  logic [5:0]      cmd_x;
  logic [4:0]      cmd_y;
  logic [3:0]      cmd_n;
  logic            spr_valid;
  logic            spr_ready;
  logic [7:0]      spr_data;
  logic            done;
  logic            collision;
  logic            busy;
  logic            scan_req;
  logic [BITS-1:0] scan_addr;
  logic [7:0]      scan_data;
  logic [BITS-1:0] vram_addr;
  logic            vram_select;
  logic            vram_write;
  logic [7:0]      vram_wdata;
  logic [7:0]      vram_rdata;
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, spr_valid, spr_data, scan_req, scan_addr, vram_rdata,
    output cmd_ready, spr_ready, done, collision, busy, scan_data, vram_addr, vram_select, vram_write, vram_wdata
  );
  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, spr_valid, spr_data, scan_req, scan_addr, vram_rdata,
    input  cmd_ready, spr_ready, done, collision, busy, scan_data, vram_addr, vram_select, vram_write, vram_wdata
  );
endinterface

// File: rtl/vram_draw_ctrl.sv
// vram_draw_ctrl: Chip-8 sprite XOR-draw and screen-clear sequencer sharing the VRAM port with scanout
module vram_draw_ctrl #(
  parameter int BITS      = 14,
  parameter int ROWS      = 32,
  parameter int ROW_BYTES = 8
) (
  input logic             clk,
  input logic             reset,
  vram_draw_ctrl_if.slave bus
);
  localparam int CLR_LAST = ROWS * ROW_BYTES - 1;
  typedef enum logic [2:0] {IDLE, FETCH, RD_L, WR_L, RD_R, WR_R, CLR, DONE} state_t;
  state_t          r_state;
  logic [5:0]      r_x;
  logic [4:0]      r_y;
  logic [3:0]      r_n;
  logic [3:0]      r_r;
  logic [7:0]      r_s;
  logic [7:0]      r_rd;
  logic [7:0]      r_wdata;
  logic [BITS-1:0] r_addr;
  logic [BITS-1:0] r_clr;
  logic            r_sel;
  logic            r_wr;
  logic            r_done;
  logic            r_coll;
  logic            r_busy;
  logic            r_cmd_ready;
  logic            r_spr_ready;
  logic [2:0]      w_c;
  logic [2:0]      w_sh;
  logic [7:0]      w_l;
  logic [7:0]      w_r;
  logic [7:0]      w_part;
  logic [BITS-1:0] w_base;
  logic [BITS-1:0] w_addr_l;
  logic [BITS-1:0] w_addr_r;
  logic            w_stall;
  logic            w_more;
  logic            w_wr_l;
  // Sprite split into left/right byte parts and their wrapped frame addresses
  always_comb begin
    w_c      = r_x[5:3];
    w_sh     = r_x[2:0];
    w_l      = r_s >> w_sh;
    w_r      = r_s << (4'd8 - {1'b0, w_sh});
    w_wr_l   = r_state == WR_L;
    w_part   = w_wr_l ? w_l : w_r;
    w_base   = BITS'(((int'(r_y) + int'(r_r)) % ROWS) * ROW_BYTES);
    w_addr_l = w_base + BITS'(w_c);
    w_addr_r = w_base + BITS'((int'(w_c) + 1) % ROW_BYTES);
    w_more   = ({1'b0, r_r} + 5'd1) < {1'b0, r_n};
    w_stall  = bus.scan_req & (r_state inside {RD_L, WR_L, RD_R, WR_R, CLR});
  end
  // Command sequencing; VRAM-touching steps hold still while scanout owns the port
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_n         <= '0;
      r_r         <= '0;
      r_s         <= '0;
      r_rd        <= '0;
      r_wdata     <= '0;
      r_addr      <= '0;
      r_clr       <= '0;
      r_sel       <= 1'b0;
      r_wr        <= 1'b0;
      r_done      <= 1'b0;
      r_coll      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_spr_ready <= 1'b0;
    end else if (!w_stall) begin
      r_done      <= 1'b0;
      r_sel       <= 1'b0;
      r_wr        <= 1'b0;
      r_spr_ready <= 1'b0;
      case (r_state)
        IDLE:
          if (bus.cmd_valid) begin
            r_x         <= bus.cmd_x;
            r_y         <= bus.cmd_y;
            r_n         <= bus.cmd_n;
            r_r         <= '0;
            r_clr       <= '0;
            r_coll      <= 1'b0;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            if (bus.cmd_op) begin
              r_state <= CLR;
              r_addr  <= '0;
              r_wdata <= 8'h00;
              r_wr    <= 1'b1;
            end else if (bus.cmd_n == 4'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= FETCH;
              r_spr_ready <= 1'b1;
            end
          end
        FETCH:
          if (bus.spr_valid) begin
            r_s     <= bus.spr_data;
            r_addr  <= w_addr_l;
            r_sel   <= 1'b1;
            r_state <= RD_L;
          end else
            r_spr_ready <= 1'b1;
        RD_L, RD_R: begin
          r_rd    <= bus.vram_rdata;
          r_wdata <= bus.vram_rdata ^ (r_state == RD_L ? w_l : w_r);
          r_wr    <= 1'b1;
          r_state <= r_state == RD_L ? WR_L : WR_R;
        end
        WR_L, WR_R: begin
          r_coll <= r_coll | (|(r_rd & w_part));
          if (w_wr_l && w_sh != 3'd0) begin
            r_addr  <= w_addr_r;
            r_sel   <= 1'b1;
            r_state <= RD_R;
          end else if (w_more) begin
            r_r         <= r_r + 4'd1;
            r_spr_ready <= 1'b1;
            r_state     <= FETCH;
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        CLR:
          if (r_clr == BITS'(CLR_LAST)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_clr  <= r_clr + 1'b1;
            r_addr <= r_clr + 1'b1;
            r_wr   <= 1'b1;
          end
        DONE: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.spr_ready   = r_spr_ready;
  assign bus.done        = r_done;
  assign bus.collision   = r_coll;
  assign bus.busy        = r_busy;
  assign bus.vram_addr   = bus.scan_req ? bus.scan_addr : r_addr;
  assign bus.vram_select = bus.scan_req | r_sel;
  assign bus.vram_write  = ~bus.scan_req & r_wr;
  assign bus.vram_wdata  = r_wdata;
  assign bus.scan_data   = bus.scan_req ? bus.vram_rdata : 8'h00;
endmodule

// File: tb/tb_vram_draw_ctrl.sv
// tb_vram_draw_ctrl: directed checks of clear, draw, wrap, scanout stall and reset abort
`timescale 1ns/1ps
module tb_vram_draw_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       preload = 1'b0;
  logic [7:0] mem [0:255];
  logic [7:0] spr_mem [0:63];
  int         spr_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  int         lat;
  int         nz;
  vram_draw_ctrl_if #(.BITS(14)) bus();
  vram_draw_ctrl #(.BITS(14), .ROWS(32), .ROW_BYTES(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.vram_rdata = mem[bus.vram_addr[7:0]];
  assign bus.spr_data   = spr_mem[spr_cnt % 64];
  // VRAM model with one-cycle bulk preload, plus sprite stream pointer
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 256; i++) mem[i] <= 8'hAA;
    else if (bus.vram_write) mem[bus.vram_addr[7:0]] <= bus.vram_wdata;
    if (bus.spr_valid && bus.spr_ready) spr_cnt <= spr_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load_spr(input logic [7:0] b0, input logic [7:0] b1);
    spr_mem[spr_cnt % 64] = b0;
    spr_mem[(spr_cnt + 1) % 64] = b1;
  endtask
  task automatic start(input logic op, input logic [5:0] x, input logic [4:0] y, input logic [3:0] n);
    int k = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_op = op;
    bus.cmd_x = x;
    bus.cmd_y = y;
    bus.cmd_n = n;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
  endtask
  task automatic wait_done();
    while (bus.done !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_n = '0;
    bus.spr_valid = 1'b1;
    bus.scan_req = 1'b0;
    bus.scan_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_collision", {31'd0, bus.collision}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_vram_write", {31'd0, bus.vram_write}, 32'd0);
    chk("rst_vram_select", {31'd0, bus.vram_select}, 32'd0);
    chk("rst_vram_addr", {18'd0, bus.vram_addr}, 32'd0);
    chk("rst_vram_wdata", {24'd0, bus.vram_wdata}, 32'd0);
    chk("rst_spr_ready", {31'd0, bus.spr_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk) preload = 1'b1;
    @(negedge clk) preload = 1'b0;
    start(1'b1, 6'd0, 5'd0, 4'd0);
    wait_done();
    chk("clr_latency", lat, 32'd256);
    chk("clr_collision", {31'd0, bus.collision}, 32'd0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'h00) nz++;
    chk("clr_nonzero_bytes", nz, 32'd0);
    load_spr(8'hFF, 8'h00);
    start(1'b0, 6'd4, 5'd0, 4'd1);
    wait_done();
    chk("draw1_latency", lat, 32'd5);
    chk("draw1_byte0", {24'd0, mem[0]}, 32'h0F);
    chk("draw1_byte1", {24'd0, mem[1]}, 32'hF0);
    chk("draw1_collision", {31'd0, bus.collision}, 32'd0);
    load_spr(8'hFF, 8'h00);
    start(1'b0, 6'd4, 5'd0, 4'd1);
    wait_done();
    chk("draw2_latency", lat, 32'd5);
    chk("draw2_byte0", {24'd0, mem[0]}, 32'h00);
    chk("draw2_byte1", {24'd0, mem[1]}, 32'h00);
    chk("draw2_collision", {31'd0, bus.collision}, 32'd1);
    load_spr(8'hFF, 8'h00);
    start(1'b0, 6'd60, 5'd3, 4'd1);
    wait_done();
    chk("hwrap_latency", lat, 32'd5);
    chk("hwrap_byte31", {24'd0, mem[31]}, 32'h0F);
    chk("hwrap_byte24", {24'd0, mem[24]}, 32'hF0);
    chk("hwrap_collision", {31'd0, bus.collision}, 32'd0);
    load_spr(8'h81, 8'h42);
    start(1'b0, 6'd0, 5'd31, 4'd2);
    chk("vwrap_busy", {31'd0, bus.busy}, 32'd1);
    chk("vwrap_spr_ready", {31'd0, bus.spr_ready}, 32'd1);
    wait_done();
    chk("vwrap_latency", lat, 32'd6);
    chk("vwrap_byte248", {24'd0, mem[248]}, 32'h81);
    chk("vwrap_byte0", {24'd0, mem[0]}, 32'h42);
    chk("vwrap_collision", {31'd0, bus.collision}, 32'd0);
    load_spr(8'hFF, 8'h00);
    start(1'b0, 6'd12, 5'd5, 4'd1);
    repeat (2) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("stall_wr_before", {31'd0, bus.vram_write}, 32'd1);
    @(negedge clk);
    bus.scan_req = 1'b1;
    bus.scan_addr = 14'd31;
    #1;
    chk("stall_scan_data", {24'd0, bus.scan_data}, 32'h0F);
    chk("stall_vram_addr", {18'd0, bus.vram_addr}, 32'd31);
    repeat (4) begin
      @(posedge clk);
      #1 lat++;
      chk("stall_no_write", {31'd0, bus.vram_write}, 32'd0);
    end
    @(negedge clk) bus.scan_req = 1'b0;
    #1;
    chk("scan_data_idle", {24'd0, bus.scan_data}, 32'h00);
    chk("stall_wr_retry", {31'd0, bus.vram_write}, 32'd1);
    wait_done();
    chk("stall_latency", lat, 32'd9);
    chk("stall_byte41", {24'd0, mem[41]}, 32'h0F);
    chk("stall_byte42", {24'd0, mem[42]}, 32'hF0);
    chk("stall_collision", {31'd0, bus.collision}, 32'd0);
    bus.spr_valid = 1'b0;
    load_spr(8'h3C, 8'h00);
    start(1'b0, 6'd0, 5'd6, 4'd1);
    repeat (3) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("fetch_wait_spr_ready", {31'd0, bus.spr_ready}, 32'd1);
    @(negedge clk) bus.spr_valid = 1'b1;
    wait_done();
    chk("fetch_stall_latency", lat, 32'd6);
    chk("fetch_stall_byte48", {24'd0, mem[48]}, 32'h3C);
    load_spr(8'hFF, 8'hFF);
    start(1'b0, 6'd20, 5'd10, 4'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rd_r_select", {31'd0, bus.vram_select}, 32'd1);
    chk("abort_rd_r_addr", {18'd0, bus.vram_addr}, 32'd83);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_vram_write", {31'd0, bus.vram_write}, 32'd0);
    chk("abort_vram_select", {31'd0, bus.vram_select}, 32'd0);
    chk("abort_vram_addr", {18'd0, bus.vram_addr}, 32'd0);
    chk("abort_spr_ready", {31'd0, bus.spr_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("abort_byte82", {24'd0, mem[82]}, 32'h0F);
    chk("abort_byte83", {24'd0, mem[83]}, 32'h00);
    chk("abort_byte90", {24'd0, mem[90]}, 32'h00);
    chk("abort_byte91", {24'd0, mem[91]}, 32'h00);
    load_spr(8'h3C, 8'h00);
    start(1'b0, 6'd0, 5'd6, 4'd1);
    wait_done();
    chk("redraw_byte48", {24'd0, mem[48]}, 32'h00);
    chk("redraw_collision", {31'd0, bus.collision}, 32'd1);
    start(1'b0, 6'd0, 5'd0, 4'd0);
    chk("n0_done_next_cycle", {31'd0, bus.done}, 32'd1);
    chk("n0_collision", {31'd0, bus.collision}, 32'd0);
    @(posedge clk);
    #1;
    chk("n0_done_pulse_end", {31'd0, bus.done}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_draw_ctrl.md
Name: vram_draw_ctrl

Overview:
- Sequences all CPU-side access to the 64x32 monochrome Chip-8 frame held in the VRAM block: sprite draw (XOR with collision detect) and screen clear.
- Shares the single VRAM port with the video scanout, which has absolute priority.
- Sits between the CPU execute unit (DXYN / 00E0 commands, sprite-byte stream) and the VRAM.
- Frame layout: 8 bytes per row, 32 rows, rows at address y*8. Byte MSB is the leftmost pixel.

Parameters:
- BITS, 14, VRAM address width; must match the VRAM instance.
- ROWS, 32, display rows; the row index wraps modulo ROWS.
- ROW_BYTES, 8, bytes per row; the column index wraps modulo ROW_BYTES.

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_op  in  1  0 = draw, 1 = clear
- cmd_x  in  6  pixel x
- cmd_y  in  5  pixel y
- cmd_n  in  4  sprite rows
- spr_valid  in  1  sprite byte available
- spr_ready  out  1  high in FETCH only
- spr_data  in  8  sprite row byte
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result of the last draw
- busy  out  1  state != IDLE
- scan_req  in  1  scanout read request
- scan_addr  in  BITS  scanout address
- scan_data  out  8  scanout read data, valid in the same cycle as scan_req
- vram_addr  out  BITS  VRAM address
- vram_select  out  1  VRAM read enable
- vram_write  out  1  VRAM write strobe, written on posedge
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data, combinational on vram_addr

Behaviour:
- Reset values while reset=0: state IDLE; done, collision, busy, vram_write and vram_select all 0; vram_addr 0; vram_wdata 0; spr_ready 0.
- Reset asserted mid-operation aborts immediately. No further VRAM write occurs, and a partially drawn frame is left as-is.
- States: IDLE, FETCH, RD_L, WR_L, RD_R, WR_R, CLR, DONE.
- IDLE:
  - cmd_valid & cmd_ready latches x, y, n and op, and clears collision.
  - op=1 goes to CLR.
  - op=0 with n=0 goes to DONE (no-op, collision stays 0).
  - Otherwise goes to FETCH with row counter r=0.
- FETCH: spr_ready=1. On spr_valid, latch the byte as s and go to RD_L.
- Address and shift calculation:
  - Row address base = ((y+r) mod ROWS)*ROW_BYTES.
  - c = x[5:3], sh = x[2:0].
  - Left part L = s >> sh, written at base+c.
  - Right part R = s << (8-sh), written at base + ((c+1) mod ROW_BYTES). The right part exists only when sh != 0.
- RD_L / RD_R: vram_select=1 at the target address; capture vram_rdata into the read-data register.
- WR_L / WR_R:
  - vram_write=1 with vram_wdata = captured ^ part.
  - collision |= |(captured & part).
- Transitions after a write:
  - WR_L goes to RD_R if sh != 0, else to the next row.
  - WR_R goes to the next row.
  - Next row: r+1 < n goes to FETCH; otherwise goes to DONE.
- CLR: write 0x00 to addresses 0..ROWS*ROW_BYTES-1, one per cycle, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. collision holds until the next accepted command.
- Arbitration:
  - While scan_req=1: vram_addr=scan_addr, vram_select=1, vram_write=0, and scan_data=vram_rdata.
  - In that cycle the controller's state, counters and captured data freeze; the stalled RD/WR/CLR step retries on the next non-stalled cycle.
  - scan_data is 0 when scan_req=0.
- Latency with no stalls and spr_valid held high:
  - done is high 3n clocks after the accepting edge for sh=0, and 5n clocks for sh != 0.
  - Clear: done is high 256 clocks after the accepting edge.
  - n=0: done is high 1 clock after the accepting edge.
- Wrap-around follows the Chip-8 convention: both x and y wrap, with no clipping.

Test Plan:
- Clear: preload VRAM 0xAA, issue op=1 → all 256 bytes = 0x00, done at +256 cycles, collision=0.
- Draw x=4, y=0, n=1, s=0xFF on a cleared frame → byte0=0x0F, byte1=0xF0, collision=0, done at +5. Repeat the same draw → bytes return to 0x00, collision=1.
- Horizontal wrap: x=60, y=3, s=0xFF → byte 31 (row 3, col 7) = 0x0F and byte 24 = 0xF0.
- Vertical wrap: x=0, y=31, n=2, s=0x81,0x42 → byte 248 = 0x81, byte 0 = 0x42, done at +6.
- Scanout stall: scan_req held high for 4 cycles during WR_L → no vram_write in those cycles, scan_data matches VRAM, result identical to the unstalled run, done delayed by exactly 4. Also check spr_valid low for 3 cycles in FETCH → done delayed by 3.
- Reset low during the RD_R of a 2-row draw → outputs at reset values, only row 0's left byte modified, cmd_ready=1 after release. A subsequent n=0 draw gives done 1 cycle after accept with collision=0.
